// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential array multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold WIDTH itself, one past the last row index.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_row_adder.sv
// One partial-product row added to a WIDTH-bit accumulator slice.
// The adder is a ripple chain of full-adder cells.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module mult_row_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] row_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a_i (acc_i[i]),
            .b_i (row_i[i]),
            .c_i (c[i]),
            .s_o (sum_o[i]),
            .c_o (c[i+1])
        );
    end

    assign cout_o = c[WIDTH];
endmodule

// File: rtl/seq_array_multiplier.sv
// Iterative WIDTH x WIDTH multiplier: one partial-product row per clock,
// unsigned or two's complement, valid/ready on both sides.
module seq_array_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [2*WIDTH-1:0] SLICE_MASK = {{(WIDTH-1){1'b0}}, {(WIDTH+1){1'b1}}};

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ov_q, ov_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH-1:0]     row, slice, row_sum;
    logic                 row_cout;
    logic [2*WIDTH-1:0]   acc_nxt;

    // -2^(WIDTH-1) negates to itself, which read unsigned is the right magnitude.
    assign a_mag = (signed_mode & a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (signed_mode & b[WIDTH-1]) ? (~b + 1'b1) : b;

    // The multiplier shifts right each row, so bit 0 is always mplier[count].
    assign row   = mcand_q & {WIDTH{mplier_q[0]}};
    assign slice = WIDTH'(acc_q >> cnt_q);

    mult_row_adder #(.WIDTH(WIDTH)) u_row (
        .acc_i  (slice),
        .row_i  (row),
        .sum_o  (row_sum),
        .cout_o (row_cout)
    );

    // Bits above count+WIDTH-1 are still zero, so the carry never ripples further.
    assign acc_nxt = (acc_q & ~(SLICE_MASK << cnt_q))
                   | ({{(WIDTH-1){1'b0}}, row_cout, row_sum} << cnt_q);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        ov_d     = ov_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_nxt;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    prod_d  = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ov_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            ov_q     <= ov_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = ov_q;
    assign product   = prod_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed checks on a 4-bit instance plus a reference-model sweep on an 8-bit one.
module tb_seq_array_multiplier;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       iv4, ir4, sm4, ov4, or4, bz4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    logic        iv8, ir8, sm8, ov8, or8, bz8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int n_cmp = 0;
    int n_err = 0;

    seq_array_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(bz4)
    );

    seq_array_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(bz8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with dut4 in IDLE; returns #1 after the edge
    // on which out_valid first rises.
    task automatic op4(input logic [3:0] aa, input logic [3:0] bb, input logic s,
                       input logic [7:0] exp, input string tag);
        chk({tag, "_rdy"}, ir4, 1);
        a4 = aa; b4 = bb; sm4 = s; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0; a4 = ~aa; b4 = ~bb; sm4 = ~s;
        chk({tag, "_busy"}, bz4, 1);
        chk({tag, "_rdy_lo"}, ir4, 0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk({tag, "_vld_early"}, ov4, 0);
            chk({tag, "_rdy_run"}, ir4, 0);
        end
        @(posedge clk); #1;
        chk({tag, "_vld"}, ov4, 1);
        chk({tag, "_prod"}, p4, exp);
        chk({tag, "_rdy_done"}, ir4, 0);
    endtask

    task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input logic s);
        logic [15:0] ref16;
        if (s) ref16 = $signed(aa) * $signed(bb);
        else   ref16 = aa * bb;
        a8 = aa; b8 = bb; sm8 = s; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        for (int i = 1; i < 8; i++) @(posedge clk);
        #1;
        chk("sw_vld_early", ov8, 0);
        @(posedge clk); #1;
        chk("sw_vld", ov8, 1);
        chk("sw_prod", p8, ref16);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        iv4 = 0; a4 = 0; b4 = 0; sm4 = 0; or4 = 1;
        iv8 = 0; a8 = 0; b8 = 0; sm8 = 0; or8 = 1;
        #12;
        chk("rst_rdy", ir4, 1);
        chk("rst_vld", ov4, 0);
        chk("rst_busy", bz4, 0);
        chk("rst_prod", p4, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        op4(4'd15, 4'd15, 1'b0, 8'hE1, "umax");
        @(posedge clk); #1;
        chk("umax_idle", ir4, 1);
        chk("umax_vld_drop", ov4, 0);

        op4(4'b1101, 4'd5, 1'b1, 8'hF1, "s_m3x5");   @(posedge clk); #1;
        op4(4'b1000, 4'b1000, 1'b1, 8'h40, "s_m8xm8"); @(posedge clk); #1;
        op4(4'b1000, 4'd7, 1'b1, 8'hC8, "s_m8x7");   @(posedge clk); #1;
        op4(4'd0, 4'd9, 1'b0, 8'h00, "zero");        @(posedge clk); #1;
        op4(4'd1, 4'd9, 1'b0, 8'h09, "ident");       @(posedge clk); #1;
        op4(4'b1101, 4'd5, 1'b0, 8'h41, "u_13x5");   @(posedge clk); #1;

        // Backpressure: product holds, in_valid ignored while DONE
        or4 = 1'b0;
        op4(4'd11, 4'd6, 1'b0, 8'h42, "bp");
        for (int i = 0; i < 5; i++) begin
            iv4 = i[0] ? 1'b0 : 1'b1;
            a4 = 4'd3; b4 = 4'd3; sm4 = 1'b0;
            @(posedge clk); #1;
            chk("bp_vld_hold", ov4, 1);
            chk("bp_prod_hold", p4, 8'h42);
            chk("bp_rdy_lo", ir4, 0);
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_rdy", ir4, 1);
        chk("bp_release_vld", ov4, 0);
        chk("bp_release_busy", bz4, 0);

        // Reset two cycles into RUN
        a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", ov4, 0);
        chk("mrst_prod", p4, 0);
        chk("mrst_rdy", ir4, 1);
        chk("mrst_busy", bz4, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op4(4'd6, 4'd7, 1'b0, 8'h2A, "post_rst");
        @(posedge clk); #1;

        // WIDTH=8 sweep: corners first, then random pairs
        op8(8'h80, 8'h80, 1'b1);
        op8(8'h80, 8'h7F, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 1000; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
